// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// fixed-latency mul/div freeze, plus stall and flush event counters.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rreg_addr1_2,
  input  logic [4:0]  Rreg_addr2_2,
  input  logic        use_rs2,
  input  logic        use_rt2,
  input  logic        MemRead3,
  input  logic [4:0]  Wreg_addr3,
  input  logic        PCSrc3,
  input  logic        MulDiv3,
  input  logic        IsDiv3,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFID_flush,
  output logic        IDEXWrite,
  output logic        IDEX_bubble,
  output logic        EXMEM_bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int unsigned EVT_W = 32;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [EVT_W-1:0] r_stall_cycles, r_flush_count;
  logic             w_lu;

  // Load-use: EX load writes a register the ID instruction reads
  assign w_lu = MemRead3 && (Wreg_addr3 != 5'd0) &&
                ((use_rs2 && (Rreg_addr1_2 == Wreg_addr3)) ||
                 (use_rt2 && (Rreg_addr2_2 == Wreg_addr3)));

  // State and busy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and pipeline controls
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IFID_flush   = 1'b0;
    IDEXWrite    = 1'b1;
    IDEX_bubble  = 1'b0;
    EXMEM_bubble = 1'b0;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    case (r_state)
      RUN: begin
        if (PCSrc3) begin
          IFID_flush  = 1'b1;
          IDEX_bubble = 1'b1;
        end else if (MulDiv3) begin
          md_start     = 1'b1;
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXWrite    = 1'b0;
          EXMEM_bubble = 1'b1;
          w_cnt_nxt    = IsDiv3 ? DIV_INIT : MUL_INIT;
          w_state_nxt  = BUSY;
        end else if (w_lu) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEX_bubble = 1'b1;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        // Counter reaching zero marks the release cycle
        if (r_cnt != '0) begin
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXWrite    = 1'b0;
          EXMEM_bubble = 1'b1;
          w_cnt_nxt    = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Event counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!PCWrite)  r_stall_cycles <= r_stall_cycles + EVT_W'(1);
      if (IFID_flush) r_flush_count <= r_flush_count + EVT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
